// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: forwarding, load-use and branch resolution, memory-wait FSM
// with a watchdog. Optional perf counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RS1E,
  input  logic [4:0]  RS2E,
  input  logic [4:0]  RDE,
  input  logic [1:0]  ResultSrcE,
  input  logic        PCSrcE,
  input  logic [4:0]  RdM,
  input  logic        RegWriteM,
  input  logic        MemReqM,
  input  logic        mem_ready,
  input  logic [4:0]  RdW,
  input  logic        RegWriteW,
  output logic        StallF,
  output logic        StallD,
  output logic        StallEM,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushW,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
`endif
  output logic        mem_err
);

  typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_e;

  localparam logic [15:0] TimeoutVal = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_err_q, mem_err_d;
  logic        load_use;

  assign load_use = (ResultSrcE == 2'b01) && (RDE != 5'd0) && ((RDE == Rs1D) || (RDE == Rs2D));
  assign mem_err  = mem_err_q;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (rst) begin
      if (RegWriteM && (RdM != 5'd0) && (RdM == RS1E)) begin
        ForwardAE = 2'b10;
      end else if (RegWriteW && (RdW != 5'd0) && (RdW == RS1E)) begin
        ForwardAE = 2'b01;
      end
      if (RegWriteM && (RdM != 5'd0) && (RdM == RS2E)) begin
        ForwardBE = 2'b10;
      end else if (RegWriteW && (RdW != 5'd0) && (RdW == RS2E)) begin
        ForwardBE = 2'b01;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallEM    = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushW     = 1'b0;

    unique case (state_q)
      StRun, StMemWait: begin
        if ((state_q == StRun) ? (MemReqM && !mem_ready) : !mem_ready) begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallEM = 1'b1;
          FlushW  = 1'b1;
          if (state_q == StRun) begin
            state_d    = StMemWait;
            wait_cnt_d = 16'd0;
          end else if (wait_cnt_q == TimeoutVal) begin
            state_d   = StHalt;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 16'd1;
          end
        end else begin
          state_d = StRun;
          // A taken branch squashes D, so a pending load-use stall is moot.
          if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
          end else if (load_use) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
      end
      StHalt: begin
        StallF  = 1'b1;
        StallD  = 1'b1;
        StallEM = 1'b1;
        FlushW  = 1'b1;
      end
      default: state_d = StRun;
    endcase

    // Hold the pipeline empty while reset is asserted.
    if (!rst) begin
      StallF  = 1'b0;
      StallD  = 1'b0;
      StallEM = 1'b0;
      FlushD  = 1'b1;
      FlushE  = 1'b1;
      FlushW  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StRun;
      wait_cnt_q <= 16'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
    end else begin
      if (StallF && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
      if (FlushD && (flush_events != 32'hFFFF_FFFF)) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Table-driven bench for hazard_ctrl with a scoreboard queue of expected output bundles.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] Rs1D, Rs2D, RS1E, RS2E, RDE, RdM, RdW;
  logic [1:0] ResultSrcE, ForwardAE, ForwardBE;
  logic       PCSrcE, RegWriteM, MemReqM, mem_ready, RegWriteW;
  logic       StallF, StallD, StallEM, FlushD, FlushE, FlushW, mem_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemReqM(MemReqM), .mem_ready(mem_ready),
    .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallEM(StallEM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .mem_err(mem_err)
  );

  // Bundle: {StallF,StallD,StallEM, FlushD,FlushE,FlushW, ForwardAE, ForwardBE, mem_err}
  localparam logic [10:0] IDLE  = 11'b000_000_00_00_0;
  localparam logic [10:0] LU    = 11'b110_010_00_00_0;
  localparam logic [10:0] BR    = 11'b000_110_00_00_0;
  localparam logic [10:0] MW    = 11'b111_001_00_00_0;
  localparam logic [10:0] RSTV  = 11'b000_111_00_00_0;
  localparam logic [10:0] HALTV = 11'b111_001_00_00_1;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] rsrc;
    logic       pcsrc;
    logic [4:0] rdm;
    logic       rwm, memreq, rdy;
    logic [4:0] rdw;
    logic       rww;
    logic [10:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [10:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic vec_t mk(string name, logic [4:0] rs1d, logic [4:0] rs2d, logic [4:0] rs1e,
                              logic [4:0] rs2e, logic [4:0] rde, logic [1:0] rsrc, logic pcsrc,
                              logic [4:0] rdm, logic rwm, logic memreq, logic rdy,
                              logic [4:0] rdw, logic rww, logic [10:0] exp);
    vec_t v;
    v.name = name; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e; v.rde = rde;
    v.rsrc = rsrc; v.pcsrc = pcsrc; v.rdm = rdm; v.rwm = rwm; v.memreq = memreq; v.rdy = rdy;
    v.rdw = rdw; v.rww = rww; v.exp = exp;
    return v;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    exp_t e;
    Rs1D = v.rs1d; Rs2D = v.rs2d; RS1E = v.rs1e; RS2E = v.rs2e; RDE = v.rde;
    ResultSrcE = v.rsrc; PCSrcE = v.pcsrc; RdM = v.rdm; RegWriteM = v.rwm;
    MemReqM = v.memreq; mem_ready = v.rdy; RdW = v.rdw; RegWriteW = v.rww;
    e.val = v.exp;
    e.name = v.name;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [10:0] act;
    act = {StallF, StallD, StallEM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, mem_err};
    if (sb.size() == 0) begin
      cmp("scoreboard_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      cmp(e.name, {21'd0, act}, {21'd0, e.val});
    end
  endtask

  task automatic step(vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    check_out();
  endtask

  initial begin
    // Reset state: forwarding candidates present but must be masked.
    drive(mk("reset", 5, 0, 3, 0, 5, 2'b01, 0, 3, 1, 0, 0, 3, 1, RSTV));
    #1 check_out();
    #20;
    @(negedge clk);
    rst = 1'b1;

    tbl.push_back(mk("lu_rs1",       5, 0, 0, 0, 5, 2'b01, 0, 0, 0, 0, 0, 0, 0, LU));
    tbl.push_back(mk("lu_released",  5, 0, 0, 0, 5, 2'b00, 0, 0, 0, 0, 0, 0, 0, IDLE));
    tbl.push_back(mk("lu_rs2",       0, 5, 0, 0, 5, 2'b01, 0, 0, 0, 0, 0, 0, 0, LU));
    tbl.push_back(mk("lu_x0",        0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0, IDLE));
    tbl.push_back(mk("lu_notload",   5, 0, 0, 0, 5, 2'b10, 0, 0, 0, 0, 0, 0, 0, IDLE));
    tbl.push_back(mk("lu_branch",    5, 0, 0, 0, 5, 2'b01, 1, 0, 0, 0, 0, 0, 0, BR));
    tbl.push_back(mk("branch",       0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, BR));
    tbl.push_back(mk("fwd_m_over_w", 0, 0, 3, 0, 0, 2'b00, 0, 3, 1, 0, 0, 3, 1,
                     11'b000_000_10_00_0));
    tbl.push_back(mk("fwd_w",        0, 0, 3, 0, 0, 2'b00, 0, 4, 1, 0, 0, 3, 1,
                     11'b000_000_01_00_0));
    tbl.push_back(mk("fwd_x0",       0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 1, IDLE));
    tbl.push_back(mk("fwd_b_w",      0, 0, 0, 3, 0, 2'b00, 0, 3, 0, 0, 0, 3, 1,
                     11'b000_000_00_01_0));
    tbl.push_back(mk("fwd_b_m",      0, 0, 0, 7, 0, 2'b00, 0, 7, 1, 0, 0, 7, 0,
                     11'b000_000_00_10_0));
    tbl.push_back(mk("fwd_a_m_b_w",  0, 0, 2, 9, 0, 2'b00, 0, 2, 1, 0, 0, 9, 1,
                     11'b000_000_10_01_0));
    tbl.push_back(mk("mem_ready_now", 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, IDLE));
    foreach (tbl[i]) step(tbl[i]);

    // Memory wait: three not-ready cycles, then ready with a branch resolving.
    step(mk("mw_enter_lu",  5, 0, 0, 0, 5, 2'b01, 0, 0, 0, 1, 0, 0, 0, MW));
    step(mk("mw_hold_br",   0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 1, 0, 0, 0, MW));
    step(mk("mw_hold_fwd",  0, 0, 3, 0, 0, 2'b00, 0, 3, 1, 1, 0, 0, 0, MW | 11'b000_000_10_00_0));
    step(mk("mw_ready_br",  0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 1, 1, 0, 0, BR));
    step(mk("mw_back_run",  0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, IDLE));
    step(mk("run_lu",       5, 0, 0, 0, 5, 2'b01, 0, 0, 0, 0, 0, 0, 0, LU));

    // Watchdog: entry cycle plus five wait cycles, then HALT with mem_err.
    step(mk("to_enter",     0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, MW));
    for (int i = 0; i < 5; i++) begin
      step(mk($sformatf("to_wait%0d", i + 1), 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0, 0, MW));
    end
    step(mk("halt",         5, 0, 0, 0, 5, 2'b01, 1, 0, 0, 1, 1, 0, 0, HALTV));
    step(mk("halt_hold",    0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, HALTV));

    // Asynchronous reset mid-cycle while halted.
    @(posedge clk);
    #2;
    drive(mk("async_rst",   0, 0, 3, 0, 0, 2'b00, 0, 3, 1, 0, 0, 0, 0, RSTV));
    rst = 1'b0;
    #1 check_out();
    @(negedge clk);
    rst = 1'b1;
    step(mk("post_rst_idle",  0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, IDLE));
    step(mk("post_rst_ready", 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0, IDLE));

`ifdef HAZARD_PERF_CNT_EN
    step(mk("perf_lu",   5, 0, 0, 0, 5, 2'b01, 0, 0, 0, 0, 0, 0, 0, LU));
    step(mk("perf_br",   0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, BR));
    step(mk("perf_idle", 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, IDLE));
    cmp("stall_cycles", stall_cycles, 32'd1);
    cmp("flush_events", flush_events, 32'd1);
`endif

    if (sb.size() != 0) cmp("scoreboard_leftover", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
